sram_ws: RTL and testbench

// - Parametrised single-port on-chip SRAM slave: next generation of the core's data/instruction RAM.
// - Adds configurable width/depth, per-byte write enables, programmable wait states and out-of-range error.
// - Sits on the core's memory port; the core stalls while HREADYOUT is low.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_ws_if.sv | 34 +++
 rtl/sram_array.sv | 42 ++++
 rtl/sram_ws.sv | 147 ++++++++++++++
 tb/tb_sram_ws.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the wait-state SRAM slave.
//   sram_state_t : access FSM states (IDLE, WAIT)
//   MAX_WAIT     : largest supported WAIT_STATES value
//   CNT_W        : width of the wait counter, sized from MAX_WAIT
//   in_range()   : byte address lies inside a DEPTH-word array
package sram_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } sram_state_t;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    // Compared in 64 bits so DEPTH*4 cannot wrap for large arrays.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return {32'd0, addr} < (64'(depth) << 2);
    endfunction

endpackage

// File: rtl/sram_ws_if.sv
// Memory-port bundle between the core (master) and the SRAM slave.
//   req          : access request, taken only while HREADYOUT=1
//   write_enable : 1=write, 0=read
//   byte_en      : per-lane write enables (NB = DATA_W/8 lanes)
//   Address      : byte address
//   write_data   : write data
//   HREADYOUT    : slave idle / access complete
//   read_data    : read data
//   resp_err     : out-of-range completion flag
interface sram_ws_if #(
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req;
    logic              write_enable;
    logic [NB-1:0]     byte_en;
    logic [31:0]       Address;
    logic [DATA_W-1:0] write_data;
    logic              HREADYOUT;
    logic [DATA_W-1:0] read_data;
    logic              resp_err;

    modport master (
        output req, write_enable, byte_en, Address, write_data,
        input  HREADYOUT, read_data, resp_err
    );

    modport slave (
        input  req, write_enable, byte_en, Address, write_data,
        output HREADYOUT, read_data, resp_err
    );

endinterface

// File: rtl/sram_array.sv
// DEPTH x DATA_W single-port storage with byte-lane write enables and a
// registered read port.
//   clk   : clock
//   we    : write strobe, lanes selected by be
//   re    : read strobe, loads rdata from mem[idx]
//   be    : byte-lane enables
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, holds between reads
module sram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int NB    = DATA_W / 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [NB-1:0]     be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset so they map onto
    // a RAM macro; the top masks rdata until a real read has completed.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/sram_ws.sv
// Single-port SRAM slave with programmable wait states, byte-lane writes and
// an out-of-range error response.
//   HCLK   : clock, all state changes on the rising edge
//   HRESET : asynchronous active-high reset
//   bus    : sram_ws_if slave port (req/write_enable/byte_en/Address/
//            write_data in; HREADYOUT/read_data/resp_err out)
// With WAIT_STATES=0 the access happens on the accepting edge straight from
// the bus; otherwise the request is captured and performed WAIT_STATES edges
// later, leaving the bus free to change while HREADYOUT is low.
module sram_ws
    import sram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic     HCLK,
    input  logic     HRESET,
    sram_ws_if.slave bus
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    sram_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              ready_q;
    logic              err_q;
    logic              zero_q;     // forces read_data to 0 (reset / bad address)

    logic              cap_we;
    logic              cap_ok;
    logic [NB-1:0]     cap_be;
    logic [IDX_W-1:0]  cap_idx;
    logic [DATA_W-1:0] cap_wdata;

    logic              accept;
    logic              req_ok;
    logic              acc_fire;
    logic              acc_we;
    logic              acc_ok;
    logic [NB-1:0]     acc_be;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = bus.req && ready_q;
    assign req_ok = in_range(bus.Address, DEPTH);

    // Select the access that completes on this edge: the live bus when there
    // are no wait states, the captured copy when the wait counter runs out.
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    always_comb begin
        if (WAIT_STATES == 0) begin
            acc_fire  = accept;
            acc_we    = bus.write_enable;
            acc_ok    = req_ok;
            acc_be    = bus.byte_en;
            acc_idx   = bus.Address[IDX_W+1:2];
            acc_wdata = bus.write_data;
        end else begin
            acc_fire  = (state == WAIT) && (cnt == '0);
            acc_we    = cap_we;
            acc_ok    = cap_ok;
            acc_be    = cap_be;
            acc_idx   = cap_idx;
            acc_wdata = cap_wdata;
        end
        // Nothing may reach the array while reset is held.
        acc_fire = acc_fire && !HRESET;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            zero_q    <= 1'b1;
            cap_we    <= 1'b0;
            cap_ok    <= 1'b0;
            cap_be    <= '0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else begin
            err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && (WAIT_STATES != 0)) begin
                        cap_we    <= bus.write_enable;
                        cap_ok    <= req_ok;
                        cap_be    <= bus.byte_en;
                        cap_idx   <= bus.Address[IDX_W+1:2];
                        cap_wdata <= bus.write_data;
                        cnt       <= CNT_LOAD;
                        state     <= WAIT;
                        ready_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion: flag bad addresses for one cycle and decide whether
            // read_data shows the array register or zero. Good writes leave
            // read_data untouched.
            if (acc_fire) begin
                err_q <= !acc_ok;
                if (!acc_ok) begin
                    zero_q <= 1'b1;
                end else if (!acc_we) begin
                    zero_q <= 1'b0;
                end
            end
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (HCLK),
        .we    (acc_fire && acc_we && acc_ok),
        .re    (acc_fire && !acc_we && acc_ok),
        .be    (acc_be),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign bus.HREADYOUT = ready_q;
    assign bus.resp_err  = err_q;
    assign bus.read_data = zero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_sram_ws.sv
// Bench for sram_ws: one instance with no wait states, one with three.
// A transaction-level model predicts HREADYOUT/read_data/resp_err for both
// and is compared every cycle; directed literal checks pin the model.
module tb_sram_ws;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } acc_t;

    logic HCLK = 1'b0;
    logic rst0 = 1'b1;
    logic rst3 = 1'b1;
    logic checking = 1'b0;

    int total  = 0;
    int passed = 0;

    always #5 HCLK = ~HCLK;

    sram_ws_if #(.DATA_W(32)) bus0 ();
    sram_ws_if #(.DATA_W(32)) bus3 ();

    sram_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) u_w0 (
        .HCLK   (HCLK),
        .HRESET (rst0),
        .bus    (bus0)
    );

    sram_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)) u_w3 (
        .HCLK   (HCLK),
        .HRESET (rst3),
        .bus    (bus3)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: index 0 -> W=0 instance, 1 -> W=3 ----------
    logic [31:0] mm [2][1024];
    acc_t        cap       [2];
    int          left      [2] = '{0, 0};
    logic        exp_ready [2] = '{1'b1, 1'b1};
    logic [31:0] exp_rd    [2] = '{32'd0, 32'd0};
    logic        exp_err   [2] = '{1'b0, 1'b0};

    function automatic int wof(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic perform(int d, acc_t a);
        logic [9:0] idx;
        if (a.addr >= 32'h0000_1000) begin
            exp_err[d] = 1'b1;
            exp_rd[d]  = 32'd0;
        end else begin
            idx = a.addr[11:2];
            if (a.we) begin
                for (int i = 0; i < 4; i++)
                    if (a.be[i]) mm[d][idx][8*i +: 8] = a.wd[8*i +: 8];
            end else begin
                exp_rd[d] = mm[d][idx];
            end
        end
    endtask

    task automatic model_step(int d, logic rst, acc_t in);
        if (rst) begin
            exp_ready[d] = 1'b1;
            exp_rd[d]    = 32'd0;
            exp_err[d]   = 1'b0;
            left[d]      = 0;
        end else begin
            exp_err[d] = 1'b0;
            if (left[d] > 0) begin
                left[d]--;
                if (left[d] == 0) begin
                    perform(d, cap[d]);
                    exp_ready[d] = 1'b1;
                end
            end else if (in.req) begin
                if (wof(d) == 0) perform(d, in);
                else begin
                    cap[d]       = in;
                    left[d]      = wof(d);
                    exp_ready[d] = 1'b0;
                end
            end
        end
    endtask

    always @(posedge HCLK or posedge rst0) begin
        acc_t a;
        a = '{bus0.req, bus0.write_enable, bus0.byte_en, bus0.Address, bus0.write_data};
        model_step(0, rst0, a);
    end

    always @(posedge HCLK or posedge rst3) begin
        acc_t a;
        a = '{bus3.req, bus3.write_enable, bus3.byte_en, bus3.Address, bus3.write_data};
        model_step(1, rst3, a);
    end

    // Single compare process, away from the active edge.
    always @(negedge HCLK) begin
        if (checking) begin
            check("w0_ready", 32'(bus0.HREADYOUT), 32'(exp_ready[0]));
            check("w0_rdata", bus0.read_data, exp_rd[0]);
            check("w0_err",   32'(bus0.resp_err), 32'(exp_err[0]));
            check("w3_ready", 32'(bus3.HREADYOUT), 32'(exp_ready[1]));
            check("w3_rdata", bus3.read_data, exp_rd[1]);
            check("w3_err",   32'(bus3.resp_err), 32'(exp_err[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(int d, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
        if (d == 0) begin
            bus0.req = 1'b1; bus0.write_enable = we; bus0.byte_en = be;
            bus0.Address = addr; bus0.write_data = wd;
        end else begin
            bus3.req = 1'b1; bus3.write_enable = we; bus3.byte_en = be;
            bus3.Address = addr; bus3.write_data = wd;
        end
        sync();
    endtask

    task automatic idle(int d);
        if (d == 0) bus0.req = 1'b0;
        else        bus3.req = 1'b0;
    endtask

    function automatic logic rdy(int d);
        return (d == 0) ? bus0.HREADYOUT : bus3.HREADYOUT;
    endfunction

    // Ends on the negedge where HREADYOUT is seen high (bounded).
    task automatic wait_ready(int d, string nm);
        int n = 0;
        @(negedge HCLK);
        while (rdy(d) !== 1'b1 && n < 40) begin
            @(negedge HCLK);
            n++;
        end
        check(nm, 32'(rdy(d)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.req = 1'b0; bus0.write_enable = 1'b0; bus0.byte_en = '0;
        bus0.Address = '0; bus0.write_data = '0;
        bus3.req = 1'b0; bus3.write_enable = 1'b0; bus3.byte_en = '0;
        bus3.Address = '0; bus3.write_data = '0;

        // Reset values
        repeat (2) @(negedge HCLK);
        rst0 = 1'b0;
        rst3 = 1'b0;
        checking = 1'b1;
        check("rst_w0_ready", 32'(bus0.HREADYOUT), 32'd1);
        check("rst_w0_rdata", bus0.read_data, 32'd0);
        check("rst_w0_err",   32'(bus0.resp_err), 32'd0);
        check("rst_w3_ready", 32'(bus3.HREADYOUT), 32'd1);
        check("rst_w3_rdata", bus3.read_data, 32'd0);
        check("rst_w3_err",   32'(bus3.resp_err), 32'd0);
        sync();

        // W=0: write then back-to-back read
        drive(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        drive(0, 1'b0, 4'h0, 32'h10, 32'h0);
        idle(0);
        @(negedge HCLK);
        check("w0_wr_rd", bus0.read_data, 32'hDEAD_BEEF);
        check("w0_ready_hi", 32'(bus0.HREADYOUT), 32'd1);
        sync();

        // W=0: byte lanes
        drive(0, 1'b1, 4'hF,    32'h20, 32'h1122_3344);
        drive(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        drive(0, 1'b0, 4'h0,    32'h20, 32'h0);
        idle(0);
        @(negedge HCLK);
        check("w0_byte_lanes", bus0.read_data, 32'h11BB_33DD);
        sync();

        // W=0: no-op write (byte_en=0) leaves the word alone
        drive(0, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
        drive(0, 1'b0, 4'h0, 32'h20, 32'h0);
        idle(0);
        @(negedge HCLK);
        check("w0_be_zero", bus0.read_data, 32'h11BB_33DD);
        sync();

        // W=0: out-of-range read, then out-of-range write leaves word 0
        drive(0, 1'b0, 4'h0, 32'h1000, 32'h0);
        idle(0);
        @(negedge HCLK);
        check("w0_oor_rdata", bus0.read_data, 32'd0);
        check("w0_oor_err",   32'(bus0.resp_err), 32'd1);
        @(negedge HCLK);
        check("w0_oor_err_clr", 32'(bus0.resp_err), 32'd0);
        sync();
        drive(0, 1'b1, 4'hF, 32'h0,    32'hCAFE_F00D);
        drive(0, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
        drive(0, 1'b0, 4'h0, 32'h0,    32'h0);
        idle(0);
        @(negedge HCLK);
        check("w0_oor_wr_word0", bus0.read_data, 32'hCAFE_F00D);
        check("w0_inrange_err",  32'(bus0.resp_err), 32'd0);
        sync();

        // W=0: last word, low address bits ignored
        drive(0, 1'b1, 4'hF, 32'hFFC, 32'h0BAD_CAFE);
        drive(0, 1'b0, 4'h0, 32'hFFF, 32'h0);
        idle(0);
        @(negedge HCLK);
        check("w0_last_word", bus0.read_data, 32'h0BAD_CAFE);
        check("w0_last_err",  32'(bus0.resp_err), 32'd0);
        sync();

        // W=3: preload two words
        drive(1, 1'b1, 4'hF, 32'h30, 32'h1234_5678);
        idle(1);
        wait_ready(1, "w3_wr30_timeout");
        sync();
        drive(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        idle(1);
        wait_ready(1, "w3_wr10_timeout");
        sync();

        // W=3: read latency, requests during WAIT ignored
        drive(1, 1'b0, 4'h0, 32'h10, 32'h0);
        bus3.req = 1'b1; bus3.write_enable = 1'b1; bus3.byte_en = 4'hF;
        bus3.Address = 32'h10; bus3.write_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("w3_ready_seq", 32'(bus3.HREADYOUT), (i < 3) ? 32'd0 : 32'd1);
            if (i == 1) bus3.Address = 32'h14;
        end
        check("w3_rd_latency", bus3.read_data, 32'hDEAD_BEEF);
        idle(1);
        sync();
        drive(1, 1'b0, 4'h0, 32'h10, 32'h0);
        idle(1);
        wait_ready(1, "w3_rd2_timeout");
        check("w3_not_queued", bus3.read_data, 32'hDEAD_BEEF);
        sync();

        // W=3: out of range
        drive(1, 1'b0, 4'h0, 32'h1000, 32'h0);
        idle(1);
        wait_ready(1, "w3_oor_timeout");
        check("w3_oor_rdata", bus3.read_data, 32'd0);
        check("w3_oor_err",   32'(bus3.resp_err), 32'd1);
        @(negedge HCLK);
        check("w3_oor_err_clr", 32'(bus3.resp_err), 32'd0);
        sync();

        // W=3: reset during the second wait cycle abandons the write
        drive(1, 1'b1, 4'hF, 32'h30, 32'h0000_0055);
        idle(1);
        @(posedge HCLK);
        #2;
        rst3 = 1'b1;
        #1;
        check("w3_rst_ready", 32'(bus3.HREADYOUT), 32'd1);
        check("w3_rst_rdata", bus3.read_data, 32'd0);
        check("w3_rst_err",   32'(bus3.resp_err), 32'd0);
        @(negedge HCLK);
        @(posedge HCLK);
        @(negedge HCLK);
        rst3 = 1'b0;
        sync();
        drive(1, 1'b0, 4'h0, 32'h30, 32'h0);
        idle(1);
        wait_ready(1, "w3_rd30_timeout");
        check("w3_rst_old_value", bus3.read_data, 32'h1234_5678);
        sync();

        repeat (3) @(negedge HCLK);
        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
